// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter streaming packets from N_REQ sources into one uart_tx
// Optional feature macro: UART_TX_ARB_CHECKSUM_EN (appends an XOR checksum byte to every packet)
// Ports:
//   clk210_p, reset_p                   210 MHz clock, asynchronous active-high reset
//   req_valid_p/req_data_p/req_last_p   per-requester byte streams, requester i on data bits [8i+7:8i]
//   req_ready_p                         byte accepted when valid & ready
//   grant_p                             one-hot owner of the UART for the current packet
//   fifo_tx_din_p/fifo_tx_wr_en_p       write side of the uart_tx FIFO
//   fifo_tx_empty_p                     uart_tx FIFO empty flag
//   transmit_req_p/transmit_done_p/transmit_done_ack_p  transmit handshake with uart_tx
//   busy_p                              high whenever the FSM is not idle
//   overflow_err_p/err_clr_p            sticky packet-too-long flag and its clear
//   pkt_count_p                         completed packets, wrapping
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic               clk210_p,
  input  logic               reset_p,
  input  logic [N_REQ-1:0]   req_valid_p,
  input  logic [8*N_REQ-1:0] req_data_p,
  input  logic [N_REQ-1:0]   req_last_p,
  output logic [N_REQ-1:0]   req_ready_p,
  output logic [N_REQ-1:0]   grant_p,
  output logic [7:0]         fifo_tx_din_p,
  output logic               fifo_tx_wr_en_p,
  input  logic               fifo_tx_empty_p,
  output logic               transmit_req_p,
  input  logic               transmit_done_p,
  output logic               transmit_done_ack_p,
  output logic               busy_p,
  output logic               overflow_err_p,
  input  logic               err_clr_p,
  output logic [15:0]        pkt_count_p
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  // Payload bytes loaded before the rest of a long packet is discarded.
`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_LEN - 1);
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_LEN);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    FLUSH     = 3'd2,
`ifdef UART_TX_ARB_CHECKSUM_EN
    CKSUM     = 3'd3,
`endif
    SEND      = 3'd4,
    WAIT_DONE = 3'd5,
    ACK       = 3'd6
  } state_t;

`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam state_t AFTER_LAST = CKSUM;
`else
  localparam state_t AFTER_LAST = SEND;
`endif

  state_t           state, state_n;
  logic [PTR_W-1:0] rr_ptr, rr_n, gidx, gidx_n, win_idx;
  logic             win_found;
  logic [N_REQ-1:0] grant_n;
  logic [7:0]       din_n;
  logic             wr_n, txreq_n, ack_n, ovf_n;
  logic [CNT_W-1:0] byte_cnt, cnt_n;
  logic [15:0]      pkt_n;
  logic             take, cur_last;
  logic [7:0]       cur_data;
`ifdef UART_TX_ARB_CHECKSUM_EN
  logic [7:0]       cksum, cksum_n;
`endif

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_valid_p[wrap_add(rr_ptr, i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr, i);
      end
    end
  end

  assign cur_data    = req_data_p[{gidx, 3'b000} +: 8];
  assign cur_last    = req_last_p[gidx];
  assign req_ready_p = (state == LOAD || state == FLUSH) ? grant_p : '0;
  assign busy_p      = (state != IDLE);

  always_comb begin
    state_n = state;
    grant_n = grant_p;
    gidx_n  = gidx;
    rr_n    = rr_ptr;
    din_n   = fifo_tx_din_p;
    wr_n    = 1'b0;
    cnt_n   = byte_cnt;
    txreq_n = transmit_req_p;
    ack_n   = transmit_done_ack_p;
    pkt_n   = pkt_count_p;
    ovf_n   = err_clr_p ? 1'b0 : overflow_err_p;
    take    = (state == LOAD || state == FLUSH) && req_valid_p[gidx];
`ifdef UART_TX_ARB_CHECKSUM_EN
    cksum_n = cksum;
`endif
    case (state)
      IDLE: begin
        // Only start a packet once the previous one has fully drained.
        if (win_found && fifo_tx_empty_p) begin
          grant_n          = '0;
          grant_n[win_idx] = 1'b1;
          gidx_n           = win_idx;
          rr_n             = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
          cnt_n            = '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
          cksum_n          = '0;
`endif
          state_n          = LOAD;
        end
      end
      LOAD: begin
        if (take) begin
          din_n = cur_data;
          wr_n  = 1'b1;
          cnt_n = byte_cnt + CNT_W'(1);
`ifdef UART_TX_ARB_CHECKSUM_EN
          cksum_n = cksum ^ cur_data;
`endif
          if (cur_last) begin
            state_n = AFTER_LAST;
          end else if (cnt_n == LIMIT) begin
            ovf_n   = 1'b1;   // set overrides a same-cycle clear
            state_n = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Drain the oversize tail; what was loaded is still sent.
        if (take && cur_last) state_n = AFTER_LAST;
      end
`ifdef UART_TX_ARB_CHECKSUM_EN
      CKSUM: begin
        din_n   = cksum;
        wr_n    = 1'b1;
        state_n = SEND;
      end
`endif
      SEND: begin
        txreq_n = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (transmit_done_p) begin
          txreq_n = 1'b0;
          ack_n   = 1'b1;
          state_n = ACK;
        end
      end
      ACK: begin
        if (!transmit_done_p) begin
          ack_n   = 1'b0;
          grant_n = '0;
          pkt_n   = pkt_count_p + 16'd1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      gidx                <= '0;
      grant_p             <= '0;
      fifo_tx_din_p       <= '0;
      fifo_tx_wr_en_p     <= 1'b0;
      byte_cnt            <= '0;
      transmit_req_p      <= 1'b0;
      transmit_done_ack_p <= 1'b0;
      overflow_err_p      <= 1'b0;
      pkt_count_p         <= '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
      cksum               <= '0;
`endif
    end else begin
      state               <= state_n;
      rr_ptr              <= rr_n;
      gidx                <= gidx_n;
      grant_p             <= grant_n;
      fifo_tx_din_p       <= din_n;
      fifo_tx_wr_en_p     <= wr_n;
      byte_cnt            <= cnt_n;
      transmit_req_p      <= txreq_n;
      transmit_done_ack_p <= ack_n;
      overflow_err_p      <= ovf_n;
      pkt_count_p         <= pkt_n;
`ifdef UART_TX_ARB_CHECKSUM_EN
      cksum               <= cksum_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int MAX_LEN = 16;
`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam int PAYLOAD_MAX = MAX_LEN - 1;
  localparam int CK          = 1;
`else
  localparam int PAYLOAD_MAX = MAX_LEN;
  localparam int CK          = 0;
`endif

  logic               clk210_p = 1'b0;
  logic               reset_p;
  logic [N_REQ-1:0]   req_valid_p, req_last_p, req_ready_p, grant_p;
  logic [8*N_REQ-1:0] req_data_p;
  logic [7:0]         fifo_tx_din_p;
  logic               fifo_tx_wr_en_p, fifo_tx_empty_p;
  logic               transmit_req_p, transmit_done_ack_p, busy_p, overflow_err_p;
  logic               transmit_done_p = 1'b0;
  logic               err_clr_p;
  logic [15:0]        pkt_count_p;

  logic       rv [N_REQ];
  logic       rl [N_REQ];
  logic [7:0] rd [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign req_valid_p[g]           = rv[g];
    assign req_last_p[g]            = rl[g];
    assign req_data_p[8*g +: 8]     = rd[g];
  end

  int total = 0;
  int passed = 0;

  logic [7:0]       wq[$];
  int               gq[$];
  int               wr_during_req = 0, grant_glitch = 0, txreq_rises = 0, ack_rises = 0;
  int               fifo_cnt = 0, dly = 0;
  logic             uart_hold = 1'b0;
  logic [N_REQ-1:0] prev_grant = '0;
  logic             prev_txreq = 1'b0, prev_ack = 1'b0;

  assign fifo_tx_empty_p = (fifo_cnt == 0);

  uart_tx_arbiter #(.N_REQ(N_REQ), .MAX_LEN(MAX_LEN)) dut (
    .clk210_p(clk210_p), .reset_p(reset_p),
    .req_valid_p(req_valid_p), .req_data_p(req_data_p), .req_last_p(req_last_p),
    .req_ready_p(req_ready_p), .grant_p(grant_p),
    .fifo_tx_din_p(fifo_tx_din_p), .fifo_tx_wr_en_p(fifo_tx_wr_en_p),
    .fifo_tx_empty_p(fifo_tx_empty_p), .transmit_req_p(transmit_req_p),
    .transmit_done_p(transmit_done_p), .transmit_done_ack_p(transmit_done_ack_p),
    .busy_p(busy_p), .overflow_err_p(overflow_err_p), .err_clr_p(err_clr_p),
    .pkt_count_p(pkt_count_p)
  );

  always #5 clk210_p = ~clk210_p;

  // uart_tx stand-in plus observers, sampled just after each rising edge.
  always @(posedge clk210_p) begin
    #1;
    if (reset_p) begin
      transmit_done_p = 1'b0;
      dly = 0; fifo_cnt = 0;
      prev_grant = '0; prev_txreq = 1'b0; prev_ack = 1'b0;
    end else begin
      if (fifo_tx_wr_en_p) begin
        wq.push_back(fifo_tx_din_p);
        fifo_cnt++;
        if (transmit_req_p) wr_during_req++;
      end
      if (grant_p != prev_grant) begin
        if (prev_grant != '0 && grant_p != '0) grant_glitch++;
        for (int i = 0; i < N_REQ; i++) if (grant_p[i]) gq.push_back(i);
      end
      if (transmit_req_p && !prev_txreq) txreq_rises++;
      if (transmit_done_ack_p && !prev_ack) ack_rises++;
      prev_grant = grant_p; prev_txreq = transmit_req_p; prev_ack = transmit_done_ack_p;
      if (transmit_req_p && !transmit_done_p && !uart_hold) begin
        dly++;
        if (dly >= 3) begin transmit_done_p = 1'b1; dly = 0; fifo_cnt = 0; end
      end else if (transmit_done_p && transmit_done_ack_p) begin
        transmit_done_p = 1'b0;
      end
    end
  end

  task automatic wait_accept(input int r);
    int t = 0;
    while (req_ready_p[r] !== 1'b1 && t < 2000) begin @(negedge clk210_p); t++; end
    total++;
    if (t >= 2000) $display("FAIL accept_timeout req%0d: ready=%b required 1", r, req_ready_p[r]);
    else passed++;
    @(negedge clk210_p);
  endtask

  task automatic send_pkt(input int r, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      rv[r] = 1'b1; rd[r] = base + 8'(k); rl[r] = (k == len - 1);
      wait_accept(r);
    end
    rv[r] = 1'b0; rl[r] = 1'b0;
  endtask

  task automatic wait_pkts(input int n);
    int t = 0;
    while (pkt_count_p !== 16'(n) && t < 3000) begin @(negedge clk210_p); t++; end
    total++;
    if (t >= 3000) $display("FAIL pkt_wait: pkt_count=%0d required %0d", pkt_count_p, n);
    else passed++;
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    repeat (3) @(negedge clk210_p);
    total++;
    if ({grant_p, req_ready_p} !== '0) $display("FAIL reset_grant_ready: got %h required 0", {grant_p, req_ready_p});
    else passed++;
    total++;
    if ({fifo_tx_wr_en_p, fifo_tx_din_p} !== 9'h0) $display("FAIL reset_fifo: got %h required 0", {fifo_tx_wr_en_p, fifo_tx_din_p});
    else passed++;
    total++;
    if ({transmit_req_p, transmit_done_ack_p, busy_p, overflow_err_p} !== 4'b0)
      $display("FAIL reset_ctrl: got %b required 0000", {transmit_req_p, transmit_done_ack_p, busy_p, overflow_err_p});
    else passed++;
    total++;
    if (pkt_count_p !== 16'h0) $display("FAIL reset_pkt_count: got %0d required 0", pkt_count_p);
    else passed++;
    reset_p = 1'b0;
    repeat (2) @(negedge clk210_p);
    total++;
    if (busy_p !== 1'b0) $display("FAIL idle_busy: got %b required 0", busy_p);
    else passed++;
  endtask

  task automatic test_basic();
    int errs = 0;
    int r0, a0;
    wq.delete(); r0 = txreq_rises; a0 = ack_rises;
    send_pkt(0, 10, 8'h20);
    wait_pkts(1);
    total++;
    if (wq.size() != 10 + CK) $display("FAIL basic_len: got %0d writes required %0d", wq.size(), 10 + CK);
    else passed++;
    for (int k = 0; k < 10; k++) if (wq[k] !== 8'h20 + 8'(k)) errs++;
    total++;
    if (errs != 0) $display("FAIL basic_data: %0d bytes differ, required 0", errs);
    else passed++;
`ifdef UART_TX_ARB_CHECKSUM_EN
    begin
      logic [7:0] x = 8'h00;
      for (int k = 0; k < 10; k++) x ^= 8'h20 + 8'(k);
      total++;
      if (wq[10] !== x) $display("FAIL basic_cksum: got %h required %h", wq[10], x);
      else passed++;
    end
`endif
    total++;
    if (txreq_rises - r0 != 1 || ack_rises - a0 != 1)
      $display("FAIL basic_handshake: req rises %0d ack rises %0d required 1 and 1", txreq_rises - r0, ack_rises - a0);
    else passed++;
    total++;
    if ({busy_p, transmit_req_p, grant_p} !== '0) $display("FAIL basic_idle: got %h required 0", {busy_p, transmit_req_p, grant_p});
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] bases [5] = '{8'h00, 8'h80, 8'h90, 8'hA0, 8'h10};
    int         exp_g [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_q[$];
    int errs = 0;
    int gl0, wd0;
    for (int p = 0; p < 5; p++) begin
`ifdef UART_TX_ARB_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      for (int k = 0; k < 3; k++) begin exp_q.push_back(bases[p] + 8'(k)); x ^= bases[p] + 8'(k); end
      exp_q.push_back(x);
`else
      for (int k = 0; k < 3; k++) exp_q.push_back(bases[p] + 8'(k));
`endif
    end
    wq.delete(); gq.delete(); gl0 = grant_glitch; wd0 = wr_during_req;
    reset_p = 1'b1;
    @(negedge clk210_p);
    fork
      begin send_pkt(0, 3, 8'h00); send_pkt(0, 3, 8'h10); end
      send_pkt(1, 3, 8'h80);
      send_pkt(2, 3, 8'h90);
      send_pkt(3, 3, 8'hA0);
      begin repeat (2) @(negedge clk210_p); reset_p = 1'b0; end
    join
    wait_pkts(5);
    total++;
    if (gq.size() != 5) $display("FAIL rr_grant_count: got %0d required 5", gq.size());
    else passed++;
    for (int i = 0; i < 5; i++) if (i >= gq.size() || gq[i] != exp_g[i]) errs++;
    total++;
    if (errs != 0) $display("FAIL rr_order: %0d grants out of order, required 0", errs);
    else passed++;
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= wq.size() || wq[i] !== exp_q[i]) errs++;
    total++;
    if (errs != 0 || wq.size() != exp_q.size())
      $display("FAIL rr_data: %0d bytes differ, %0d writes required %0d", errs, wq.size(), exp_q.size());
    else passed++;
    total++;
    if (grant_glitch - gl0 != 0) $display("FAIL rr_grant_stable: got %0d changes required 0", grant_glitch - gl0);
    else passed++;
    total++;
    if (wr_during_req - wd0 != 0) $display("FAIL rr_write_during_req: got %0d required 0", wr_during_req - wd0);
    else passed++;
  endtask

  task automatic test_overflow();
    int errs = 0;
    int p0, r0;
    wq.delete(); p0 = pkt_count_p; r0 = txreq_rises;
    send_pkt(2, 20, 8'h40);
    wait_pkts(p0 + 1);
    total++;
    if (wq.size() != PAYLOAD_MAX + CK) $display("FAIL ovf_len: got %0d writes required %0d", wq.size(), PAYLOAD_MAX + CK);
    else passed++;
    for (int k = 0; k < PAYLOAD_MAX; k++) if (wq[k] !== 8'h40 + 8'(k)) errs++;
    total++;
    if (errs != 0) $display("FAIL ovf_data: %0d bytes differ, required 0", errs);
    else passed++;
`ifdef UART_TX_ARB_CHECKSUM_EN
    begin
      logic [7:0] x = 8'h00;
      for (int k = 0; k < PAYLOAD_MAX; k++) x ^= 8'h40 + 8'(k);
      total++;
      if (wq[PAYLOAD_MAX] !== x) $display("FAIL ovf_cksum: got %h required %h", wq[PAYLOAD_MAX], x);
      else passed++;
    end
`endif
    total++;
    if (txreq_rises - r0 != 1) $display("FAIL ovf_transmitted: got %0d requests required 1", txreq_rises - r0);
    else passed++;
    repeat (3) @(negedge clk210_p);
    total++;
    if (overflow_err_p !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", overflow_err_p);
    else passed++;
    err_clr_p = 1'b1;
    @(negedge clk210_p);
    err_clr_p = 1'b0;
    total++;
    if (overflow_err_p !== 1'b0) $display("FAIL ovf_clear: got %b required 0", overflow_err_p);
    else passed++;
  endtask

  task automatic test_gap();
    int errs = 0;
    int p0, n0;
    int gbad = 0;
    wq.delete(); p0 = pkt_count_p;
    for (int k = 0; k < 3; k++) begin
      rv[1] = 1'b1; rd[1] = 8'h60 + 8'(k); rl[1] = 1'b0;
      wait_accept(1);
    end
    rv[1] = 1'b0;
    @(negedge clk210_p);
    n0 = wq.size();
    repeat (4) begin
      @(negedge clk210_p);
      if (grant_p !== 4'b0010) gbad++;
    end
    total++;
    if (wq.size() != n0 || n0 != 3) $display("FAIL gap_writes: got %0d writes required 3", wq.size());
    else passed++;
    total++;
    if (gbad != 0) $display("FAIL gap_grant: %0d cycles lost grant, required 0", gbad);
    else passed++;
    for (int k = 3; k < 8; k++) begin
      rv[1] = 1'b1; rd[1] = 8'h60 + 8'(k); rl[1] = (k == 7);
      wait_accept(1);
    end
    rv[1] = 1'b0; rl[1] = 1'b0;
    wait_pkts(p0 + 1);
    for (int k = 0; k < 8; k++) if (wq[k] !== 8'h60 + 8'(k)) errs++;
    total++;
    if (errs != 0 || wq.size() != 8 + CK) $display("FAIL gap_order: %0d bytes differ, %0d writes required %0d", errs, wq.size(), 8 + CK);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int t = 0;
    uart_hold = 1'b1;
    send_pkt(1, 2, 8'h70);
    while (transmit_req_p !== 1'b1 && t < 200) begin @(negedge clk210_p); t++; end
    total++;
    if (t >= 200) $display("FAIL mid_req_timeout: transmit_req=%b required 1", transmit_req_p);
    else passed++;
    repeat (2) @(negedge clk210_p);
    reset_p = 1'b1;
    @(posedge clk210_p);
    #1;
    total++;
    if ({grant_p, req_ready_p, fifo_tx_wr_en_p, transmit_req_p, transmit_done_ack_p, busy_p, overflow_err_p} !== '0 || pkt_count_p !== 16'h0)
      $display("FAIL mid_reset_outputs: got %h/%0d required 0/0",
               {grant_p, req_ready_p, fifo_tx_wr_en_p, transmit_req_p, transmit_done_ack_p, busy_p, overflow_err_p}, pkt_count_p);
    else passed++;
    @(negedge clk210_p);
    uart_hold = 1'b0;
    reset_p = 1'b0;
    @(negedge clk210_p);
    wq.delete(); gq.delete();
    fork
      send_pkt(0, 2, 8'hB0);
      send_pkt(2, 2, 8'hC0);
    join
    wait_pkts(2);
    total++;
    if (gq.size() != 2 || gq[0] != 0 || gq[1] != 2)
      $display("FAIL mid_pointer: got %0d grants, first %0d, required 2 grants 0 then 2", gq.size(), (gq.size() > 0) ? gq[0] : -1);
    else passed++;
  endtask

  task automatic test_single();
    int p0;
    wq.delete(); p0 = pkt_count_p;
    send_pkt(3, 1, 8'h55);
    wait_pkts(p0 + 1);
    total++;
    if (wq.size() != 1 + CK || wq[0] !== 8'h55) $display("FAIL single: got %0d writes first %h required %0d writes of 55", wq.size(), wq[0], 1 + CK);
    else passed++;
`ifdef UART_TX_ARB_CHECKSUM_EN
    total++;
    if (wq[1] !== 8'h55) $display("FAIL single_cksum: got %h required 55", wq[1]);
    else passed++;
`endif
    repeat (2) @(negedge clk210_p);
    total++;
    if (busy_p !== 1'b0 || pkt_count_p !== 16'(p0 + 1)) $display("FAIL single_done: busy=%b count=%0d required 0 and %0d", busy_p, pkt_count_p, p0 + 1);
    else passed++;
  endtask

  initial begin
    reset_p = 1'b1;
    err_clr_p = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin rv[i] = 1'b0; rl[i] = 1'b0; rd[i] = 8'h00; end
    test_reset();
    test_basic();
    test_round_robin();
    test_overflow();
    test_gap();
    test_reset_mid();
    test_single();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
